nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle sequencer for a WIDTH-bit add/subtract built on one shared 4-bit ripple adder slice.
- Instantiates a single 4-bit adder (4-bit A/B, carry in, 4-bit sum, carry out) and feeds it one nibble per cycle, least-significant nibble first.
- Carries between nibbles through a registered carry.
- Used in the ALU area where area matters more than latency; presents a start/busy/done handshake to its master.

Parameters:
- NUM_NIBBLES, 4, number of 4-bit slices per operation; operand width WIDTH = 4*NUM_NIBBLES, legal range 2..8.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only when accepting (state IDLE or DONE).
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- Sum  output  WIDTH  registered result; holds until the next completion.
- C_out  output  1  registered carry out of MSB; for sub, 1 = no borrow.
- Ovfl  output  1  registered two's-complement signed overflow.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Sum/C_out/Ovfl update.

Behaviour:
- Reset (async, rst=1): state=IDLE; Sum=0, C_out=0, Ovfl=0, busy=0, done=0; internal operand/result shift registers, carry register and nibble counter cleared.
- States:
  - IDLE: start=1 -> RUN; else stay.
  - RUN: nibble counter idx runs 0..NUM_NIBBLES-1; on idx=NUM_NIBBLES-1 -> DONE; else idx+1.
  - DONE: start=1 -> RUN (back-to-back accepted); else -> IDLE.
- Accept (edge where start=1 in IDLE or DONE):
  - latch opA=A, opB = sub ? ~B : B;
  - carry reg = sub;
  - idx=0; busy=1 after this edge.
- RUN edge, per nibble:
  - adder inputs are opA[3:0], opB[3:0], carry reg;
  - adder sum nibble shifted into the top of the result shift register;
  - opA and opB shifted right by 4;
  - carry reg = adder carry out.
  - Before the last nibble, capture the carry into the MSB: c15 = opA[3]^opB[3]^sum[3] of the final slice.
- Completion (last RUN edge):
  - Sum = full result;
  - C_out = final carry out;
  - Ovfl = c15 XOR C_out;
  - done=1 and busy=0 for the following cycle (state DONE).
- Latency: start-sampling edge k -> done high and results valid after edge k+NUM_NIBBLES, i.e. 4 cycles at default.
  - Throughput: one op per NUM_NIBBLES cycles when start is asserted in the DONE cycle.
- start while busy=1: ignored; A, B, sub changes during RUN have no effect (operands latched).
- Sum, C_out, Ovfl never show partial results; they change only on the completion edge.
- done never asserts without a preceding accepted start.
- Reset mid-operation: operation aborted immediately, all outputs return to reset values, no done pulse.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1. Ovfl uses the signed interpretation for both add and sub.

Test Plan:
- Reset then add A=0xFFFF, B=0x0001, sub=0 -> done exactly 4 cycles after start edge; Sum=0x0000, C_out=1, Ovfl=0; busy high those 4 cycles.
- Add A=0x7FFF, B=0x0001 -> Sum=0x8000, C_out=0, Ovfl=1; add A=0x1234, B=0x4321 -> Sum=0x5555, C_out=0, Ovfl=0.
- Sub A=0x0005, B=0x0007 -> Sum=0xFFFE, C_out=0, Ovfl=0; sub A=0x8000, B=0x0001 -> Sum=0x7FFF, C_out=1, Ovfl=1.
- start pulsed again mid-RUN with different A/B -> ignored, original result produced. Then start held in the DONE cycle with A=0x0F0F, B=0x00F1 -> second result 0x1000 four cycles later, no idle gap.
- Assert rst during third RUN cycle -> Sum/C_out/Ovfl/busy/done go 0 asynchronously; no done pulse after release; next op completes correctly.
- NUM_NIBBLES=2 build: A=0xFF, B=0x01 add -> done after 2 cycles, Sum=0x00, C_out=1, Ovfl=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if
//   Handshake and data bundle between a master and the nibble-serial
//   add/sub sequencer.
//   master: drives start, sub, A, B; receives Sum, C_out, Ovfl, busy, done.
//   slave : the sequencer side of the same signals.
interface nibble_serial_add_ctrl_if #(
  parameter int NUM_NIBBLES = 4
);
  localparam int WIDTH = 4 * NUM_NIBBLES;

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
  logic             Ovfl;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, A, B,
    input  Sum, C_out, Ovfl, busy, done
  );

  modport slave (
    input  start, sub, A, B,
    output Sum, C_out, Ovfl, busy, done
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   WIDTH-bit (WIDTH = 4*NUM_NIBBLES) add/subtract sequenced through one
//   shared 4-bit adder slice, one nibble per cycle, LS nibble first, with
//   the inter-nibble carry held in a register.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of nibble_serial_add_ctrl_if
//         start/sub/A/B sampled when idle or done; Sum/C_out/Ovfl registered
//         results; busy while sequencing; done one-cycle completion pulse.

// 4-bit ripple slice shared by every nibble of an operation.
module nibble_add4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [4:0] w_full;
  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_c};
  assign o_s    = w_full[3:0];
  assign o_c    = w_full[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_add_ctrl_if.slave  bus
);
  localparam int WIDTH = 4 * NUM_NIBBLES;
  localparam int IDX_W = $clog2(NUM_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovfl;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_res_next;

  nibble_add4 u_add (
    .i_a (r_opa[3:0]),
    .i_b (r_opb[3:0]),
    .i_c (r_carry),
    .o_s (w_sum),
    .o_c (w_cout)
  );

  // Carry into the MSB of the current slice; only meaningful on the last
  // nibble, where it pairs with the carry out to flag signed overflow.
  assign w_c_msb = r_opa[3] ^ r_opb[3] ^ w_sum[3];

  // New nibble enters at the top; after NUM_NIBBLES shifts the first
  // nibble has walked down to bit 0.
  assign w_res_next = WIDTH'({w_sum, r_res} >> 4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovfl  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            // Subtraction as A + ~B + 1: the +1 rides in on the first carry.
            r_opa   <= bus.A;
            r_opb   <= bus.sub ? ~bus.B : bus.B;
            r_carry <= bus.sub;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_res   <= w_res_next;
          r_opa   <= r_opa >> 4;
          r_opb   <= r_opb >> 4;
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_sum   <= w_res_next;
            r_cout  <= w_cout;
            r_ovfl  <= w_c_msb ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Sum   = r_sum;
  assign bus.C_out = r_cout;
  assign bus.Ovfl  = r_ovfl;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule
